uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Host-side controller for the UART receiver. It owns the receiver's runtime configuration (prescale, parity enable, parity type) and applies changes only while the receiver is idle. It captures each valid received byte into a small FIFO and presents it on a ready/valid stream. It also keeps saturating counters for overrun, parity and stop-bit errors. It sits between the UART RX core (FSM, sampler, deserializer, checkers) and the register/bus interface.

## Interface
Parameters:
- DATA_WIDTH, 8, received byte width
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, ≥2
- DEF_PRESCALE, 8, prescale applied at reset
- DEF_PAR_EN, 1, parity enable applied at reset
- DEF_PAR_TYP, 0, parity type applied at reset (0 even, 1 odd)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_wr  in  1  one-cycle configuration write strobe
- cfg_prescale  in  6  requested prescale; legal values 8, 16, 32 only
- cfg_par_en  in  1  requested parity enable
- cfg_par_typ  in  1  requested parity type
- cfg_pending  out  1  a legal write is held, waiting for the receiver to go idle
- cfg_err  out  1  one-cycle pulse: the last cfg_wr carried an illegal prescale
- prescale  out  6  applied prescale, to the RX core
- PAR_EN  out  1  applied parity enable, to the RX core
- PAR_TYP  out  1  applied parity type, to the RX core
- rx_busy  in  1  RX core enable; high while a frame is in progress
- rx_data  in  DATA_WIDTH  deserializer parallel output
- rx_data_valid  in  1  RX core data_valid; level, high for several cycles during the stop bit
- rx_par_err  in  1  parity checker flag, valid at frame end
- rx_stp_err  in  1  stop checker flag, valid at frame end
- m_data  out  DATA_WIDTH  FIFO head
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts m_data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- clr_cnt  in  1  synchronous clear of all error counters
- ovr_cnt, par_err_cnt, stp_err_cnt  out  8 each  saturating error counters

## Operation
Configuration FSM:
- States: CFG_IDLE and CFG_PEND.
- Writes with an illegal prescale are rejected: no state change, cfg_err pulses the next cycle.
- CFG_IDLE, legal cfg_wr, rx_busy=0: applied outputs update on the next edge. The FSM stays in CFG_IDLE.
- CFG_IDLE, legal cfg_wr, rx_busy=1: the write is latched into shadow registers and the FSM moves to CFG_PEND.
- CFG_PEND, legal cfg_wr: the shadow registers are overwritten (last write wins).
- CFG_PEND, first cycle with rx_busy=0: the shadow is applied and the FSM returns to CFG_IDLE.
- cfg_pending = (state == CFG_PEND).
- Applied outputs never change while rx_busy=1.

Byte capture:
- A push occurs on the rising edge of rx_data_valid: registered previous value 0, current value 1. This gives exactly one push per frame, whatever the prescale.
- Push while the FIFO is full and m_ready=0: the byte is dropped and ovr_cnt increments.
- Push while the FIFO is full and a pop occurs in the same cycle: the push is accepted.
- Pop = m_valid & m_ready.

Error counting:
- At the frame-end event (rx_busy falling edge, 1→0): rx_par_err increments par_err_cnt and rx_stp_err increments stp_err_cnt. Both may increment on the same event.
- All counters saturate at 255.
- clr_cnt wins over a coincident increment.

## Timing
- Reset values: prescale=DEF_PRESCALE, PAR_EN=DEF_PAR_EN, PAR_TYP=DEF_PAR_TYP, cfg_pending=0, cfg_err=0, m_valid=0, m_data=0, fifo_level=0, all counters 0, FSM in CFG_IDLE, edge-detect registers 0.
- Config latency: 1 cycle from cfg_wr (idle case), or from the first rx_busy=0 cycle (pending case).
- Capture latency: a push in cycle N gives m_valid=1 in cycle N+1. There is no same-cycle fall-through.
- m_data is stable while m_valid=1 and m_ready=0.
- fifo_level updates one cycle after the push/pop event. It is unchanged when a push and a pop occur in the same cycle.
- Reset mid-frame or with the FIFO non-empty: FIFO flushed, pending configuration discarded, default configuration restored.

## Structure
- Package uart_rx_pkg holds the legal prescale constants (8, 16, 32), the CFG state encoding, and the default configuration constants.
- One sub-module, uart_rx_fifo: a synchronous FIFO with push, pop, full, empty and level.
- The configuration FSM, edge detection and counters live in uart_rx_ctrl.

## Test plan
- Reset, then idle write of prescale=16, par_en=0 → prescale=16 and PAR_EN=0 one cycle later; cfg_pending stays 0.
- Write prescale=32 while rx_busy=1 → cfg_pending=1 and prescale unchanged. After rx_busy falls → prescale=32 one cycle later and cfg_pending=0.
- Write prescale=12 → cfg_err pulses once; applied configuration and FSM state unchanged.
- With m_ready=0, five frames (each with rx_data_valid high for 8 cycles) carrying 0xA1–0xA5 → fifo_level=4 and ovr_cnt=1. Drain → bytes A1, A2, A3, A4 in order.
- Frame end with rx_par_err=1 and rx_stp_err=1 → both counters increment by 1. Repeat 300 frames → both counters at 255. clr_cnt together with a frame end → counters read 0.
- Assert reset mid-frame with 2 bytes queued → m_valid=0, fifo_level=0, default configuration restored.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants and helpers for the UART receiver host-side controller.
//   - Legal prescale values accepted by the RX core (8, 16, 32)
//   - Configuration FSM state encoding
//   - Default runtime configuration restored at reset
//   - Small helpers for prescale legality and saturating counters
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int   DEF_PRESCALE_C = 8;
    localparam logic DEF_PAR_EN_C   = 1'b1;
    localparam logic DEF_PAR_TYP_C  = 1'b0;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_e;

    // Only the three sampling ratios the RX core supports are accepted.
    function automatic logic isLegalPrescale(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

    // Error counters stick at their maximum instead of wrapping.
    function automatic logic [7:0] satInc(input logic [7:0] c);
        return (c == CNT_MAX) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous byte FIFO between the RX capture logic and the consumer.
// The head entry is presented combinationally from storage; there is no
// same-cycle fall-through, so a pushed byte becomes visible one cycle later.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (flushes the FIFO)
//   push_i       write data_i (ignored when full unless pop_i is also high)
//   pop_i        remove the head entry (ignored when empty)
//   data_i       write data
//   data_o       head entry
//   full_o       FIFO holds DEPTH entries
//   empty_o      FIFO holds no entries
//   level_o      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wrPtr_q;
    logic [AW:0]           rdPtr_q;
    logic                  doPush;
    logic                  doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o = wrPtr_q - rdPtr_q;
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, since the slot being freed is the one written.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    assign data_o = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= data_i;
                wrPtr_q                <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Host-side controller for the UART receiver.
//   - Holds the runtime configuration (prescale, parity enable/type) and only
//     lets it change while the receiver is idle; writes arriving mid-frame are
//     parked in shadow registers until the frame ends.
//   - Captures one byte per frame on the rising edge of rx_data_valid into a
//     FIFO and presents it as a ready/valid stream.
//   - Keeps saturating overrun, parity-error and stop-error counters.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cfg_wr, cfg_prescale,
//   cfg_par_en, cfg_par_typ            configuration write request
//   cfg_pending                        legal write waiting for receiver idle
//   cfg_err                            pulse: last write had illegal prescale
//   prescale, PAR_EN, PAR_TYP          applied configuration to the RX core
//   rx_busy, rx_data, rx_data_valid,
//   rx_par_err, rx_stp_err             status from the RX core
//   m_data, m_valid, m_ready           received byte stream
//   fifo_level                         FIFO occupancy
//   clr_cnt                            synchronous clear of error counters
//   ovr_cnt, par_err_cnt, stp_err_cnt  saturating error counters
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DEF_PRESCALE = DEF_PRESCALE_C,
    parameter bit DEF_PAR_EN   = DEF_PAR_EN_C,
    parameter bit DEF_PAR_TYP  = DEF_PAR_TYP_C
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_wr,
    input  logic [5:0]                    cfg_prescale,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_typ,
    output logic                          cfg_pending,
    output logic                          cfg_err,
    output logic [5:0]                    prescale,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    input  logic                          rx_busy,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_data_valid,
    input  logic                          rx_par_err,
    input  logic                          rx_stp_err,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clr_cnt,
    output logic [7:0]                    ovr_cnt,
    output logic [7:0]                    par_err_cnt,
    output logic [7:0]                    stp_err_cnt
);

    localparam logic [5:0] DEF_PRESCALE_V = 6'(DEF_PRESCALE);

    cfg_state_e cfgState_q;
    logic [5:0] prescale_q;
    logic       parEn_q;
    logic       parTyp_q;
    logic [5:0] shadowPrescale_q;
    logic       shadowParEn_q;
    logic       shadowParTyp_q;
    logic       cfgErr_q;

    logic       rxDvPrev_q;
    logic       rxBusyPrev_q;
    logic [7:0] ovrCnt_q;
    logic [7:0] parErrCnt_q;
    logic [7:0] stpErrCnt_q;

    logic       wrLegal;
    logic       pushEvt;
    logic       frameEnd;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       popEvt;

    assign wrLegal  = cfg_wr && isLegalPrescale(cfg_prescale);
    assign pushEvt  = rx_data_valid && !rxDvPrev_q;
    assign frameEnd = rxBusyPrev_q && !rx_busy;
    assign m_valid  = !fifoEmpty;
    assign popEvt   = m_valid && m_ready;

    assign prescale    = prescale_q;
    assign PAR_EN      = parEn_q;
    assign PAR_TYP     = parTyp_q;
    assign cfg_pending = (cfgState_q == CFG_PEND);
    assign cfg_err     = cfgErr_q;
    assign ovr_cnt     = ovrCnt_q;
    assign par_err_cnt = parErrCnt_q;
    assign stp_err_cnt = stpErrCnt_q;

    // Configuration FSM. Applied registers only move on a cycle where
    // rx_busy is low. A write that coincides with the pending frame ending
    // is the newest request, so it is applied in place of the shadow copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgState_q       <= CFG_IDLE;
            prescale_q       <= DEF_PRESCALE_V;
            parEn_q          <= DEF_PAR_EN;
            parTyp_q         <= DEF_PAR_TYP;
            shadowPrescale_q <= DEF_PRESCALE_V;
            shadowParEn_q    <= DEF_PAR_EN;
            shadowParTyp_q   <= DEF_PAR_TYP;
            cfgErr_q         <= 1'b0;
        end else begin
            cfgErr_q <= cfg_wr && !isLegalPrescale(cfg_prescale);
            case (cfgState_q)
                CFG_IDLE: begin
                    if (wrLegal) begin
                        if (!rx_busy) begin
                            prescale_q <= cfg_prescale;
                            parEn_q    <= cfg_par_en;
                            parTyp_q   <= cfg_par_typ;
                        end else begin
                            shadowPrescale_q <= cfg_prescale;
                            shadowParEn_q    <= cfg_par_en;
                            shadowParTyp_q   <= cfg_par_typ;
                            cfgState_q       <= CFG_PEND;
                        end
                    end
                end
                CFG_PEND: begin
                    if (!rx_busy) begin
                        if (wrLegal) begin
                            prescale_q <= cfg_prescale;
                            parEn_q    <= cfg_par_en;
                            parTyp_q   <= cfg_par_typ;
                        end else begin
                            prescale_q <= shadowPrescale_q;
                            parEn_q    <= shadowParEn_q;
                            parTyp_q   <= shadowParTyp_q;
                        end
                        cfgState_q <= CFG_IDLE;
                    end else if (wrLegal) begin
                        shadowPrescale_q <= cfg_prescale;
                        shadowParEn_q    <= cfg_par_en;
                        shadowParTyp_q   <= cfg_par_typ;
                    end
                end
                default: cfgState_q <= CFG_IDLE;
            endcase
        end
    end

    // Edge detectors and error counters. rx_data_valid stays high for
    // several cycles per frame, so only its rising edge counts as a byte;
    // the falling edge of rx_busy marks the frame end where the checker
    // flags are meaningful. A clear request overrides any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxDvPrev_q   <= 1'b0;
            rxBusyPrev_q <= 1'b0;
            ovrCnt_q     <= '0;
            parErrCnt_q  <= '0;
            stpErrCnt_q  <= '0;
        end else begin
            rxDvPrev_q   <= rx_data_valid;
            rxBusyPrev_q <= rx_busy;
            if (clr_cnt) begin
                ovrCnt_q    <= '0;
                parErrCnt_q <= '0;
                stpErrCnt_q <= '0;
            end else begin
                if (pushEvt && fifoFull && !popEvt) begin
                    ovrCnt_q <= satInc(ovrCnt_q);
                end
                if (frameEnd && rx_par_err) begin
                    parErrCnt_q <= satInc(parErrCnt_q);
                end
                if (frameEnd && rx_stp_err) begin
                    stpErrCnt_q <= satInc(stpErrCnt_q);
                end
            end
        end
    end

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) uFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushEvt),
        .pop_i   (popEvt),
        .data_i  (rx_data),
        .data_o  (m_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

endmodule
